// File: rtl/fb_read_arbiter_pkg.sv
// Shared types and defaults for the framebuffer read-port arbiter.
package fb_read_arbiter_pkg;

    localparam int unsigned FB_ADDR_BITS  = 16;
    localparam int unsigned FB_DATA_WIDTH = 4;
    localparam logic [7:0]  DROP_MAX      = 8'hFF;

    // Which requester issued a given read.
    typedef enum logic {
        OWNER_VGA = 1'b0,
        OWNER_ETH = 1'b1
    } owner_e;

    // One in-flight read travelling alongside the BRAM latency.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/fb_read_arbiter_swap_gate.sv
// Defers buffer swaps while an Ethernet export is reading a frame,
// merges swap requests that arrive while one is deferred, and counts them.
module fb_read_arbiter_swap_gate
    import fb_read_arbiter_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       swap_req_in,
    input  logic       frame_active_in,
    output logic       swap_out,
    output logic [7:0] dropped_swaps_out
);

    logic       pending_q, pending_d;
    logic       swap_q, swap_d;
    logic [7:0] dropped_q, dropped_d;
    logic       fire;

    // A swap fires when one is wanted and the exporter is idle; a fire that
    // would follow directly on the previous pulse is held as pending instead.
    always_comb begin
        fire      = !frame_active_in && (pending_q || swap_req_in) && !swap_q;
        swap_d    = fire;
        pending_d = (pending_q || swap_req_in) && !fire;
        dropped_d = dropped_q;
        if (swap_req_in && pending_q && (dropped_q != DROP_MAX)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // Registered swap state, cleared by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_q <= 1'b0;
            swap_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            pending_q <= pending_d;
            swap_q    <= swap_d;
            dropped_q <= dropped_d;
        end
    end

    assign swap_out          = swap_q;
    assign dropped_swaps_out = dropped_q;

endmodule

// File: rtl/fb_read_arbiter.sv
// Fixed-priority arbiter for the framebuffer BRAM read port: VGA first,
// Ethernet best-effort, with a tag pipeline routing returned data.
module fb_read_arbiter
    import fb_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = FB_ADDR_BITS,
    parameter int unsigned DATA_WIDTH   = FB_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  vga_req_in,
    input  logic [ADDR_BITS-1:0]  vga_addr_in,
    output logic [DATA_WIDTH-1:0] vga_data_out,
    output logic                  vga_valid_out,
    input  logic                  eth_req_in,
    input  logic [ADDR_BITS-1:0]  eth_addr_in,
    output logic                  eth_gnt_out,
    output logic [DATA_WIDTH-1:0] eth_data_out,
    output logic                  eth_valid_out,
    input  logic                  eth_frame_active_in,
    input  logic                  swap_req_in,
    output logic                  swap_out,
    output logic [ADDR_BITS-1:0]  bram_addr_out,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic [7:0]            dropped_swaps_out,
    output logic                  eth_starved_out
);

    localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [ADDR_BITS-1:0] held_q, held_d;
    tag_t                 tag_q [READ_LATENCY];
    tag_t                 tag_d;
    logic [CW-1:0]        starve_q, starve_d;
    logic                 starved_q;
    tag_t                 tag_out;

    // Grant, address mux and the new tag for this cycle's issue.
    always_comb begin
        eth_gnt_out = eth_req_in && !vga_req_in && !rst_in;
        held_d      = held_q;
        tag_d       = '0;
        if (vga_req_in) begin
            bram_addr_out = vga_addr_in;
            held_d        = vga_addr_in;
            tag_d         = '{valid: 1'b1, owner: OWNER_VGA};
        end else if (eth_req_in) begin
            bram_addr_out = eth_addr_in;
            if (eth_gnt_out) begin
                held_d = eth_addr_in;
                tag_d  = '{valid: 1'b1, owner: OWNER_ETH};
            end
        end else begin
            bram_addr_out = held_q;
        end
    end

    // Starvation count: runs while Ethernet waits, saturates at the limit.
    always_comb begin
        starve_d = '0;
        if (eth_req_in && !eth_gnt_out) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
        end
    end

    // Held address, tag shift register and starvation state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            held_q    <= '0;
            starve_q  <= '0;
            starved_q <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            held_q    <= held_d;
            starve_q  <= starve_d;
            starved_q <= (starve_d >= LIMIT);
            tag_q[0]  <= tag_d;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Valids are masked during reset since the synchronous clear of the
    // tags only takes effect at the next edge.
    assign tag_out       = tag_q[READ_LATENCY-1];
    assign vga_valid_out = tag_out.valid && (tag_out.owner == OWNER_VGA) && !rst_in;
    assign eth_valid_out = tag_out.valid && (tag_out.owner == OWNER_ETH) && !rst_in;
    assign vga_data_out  = bram_data_in;
    assign eth_data_out  = bram_data_in;
    assign eth_starved_out = starved_q;

    fb_read_arbiter_swap_gate u_swap_gate (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .swap_req_in       (swap_req_in),
        .frame_active_in   (eth_frame_active_in),
        .swap_out          (swap_out),
        .dropped_swaps_out (dropped_swaps_out)
    );

endmodule
